// File: rtl/alu_pkg.sv
// Shared constants and state encoding for the ALU command front end.
package alu_pkg;
  localparam logic [3:0] UNIT_ARITH = 4'b0001;
  localparam logic [3:0] UNIT_LOGIC = 4'b0010;
  localparam logic [3:0] UNIT_CMP   = 4'b0100;
  localparam logic [3:0] UNIT_SHIFT = 4'b1000;

  localparam logic [1:0] FUNC_ARITH = 2'b00;
  localparam logic [1:0] FUNC_LOGIC = 2'b01;
  localparam logic [1:0] FUNC_CMP   = 2'b10;
  localparam logic [1:0] FUNC_SHIFT = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} issuer_state_e;
endpackage

// File: rtl/alu_func_encoder.sv
// One-hot unit select to 2-bit alu_func code; inverse of the ALU unit decoder.
module alu_func_encoder
  import alu_pkg::*;
(
  input  logic [3:0] unit,
  output logic [1:0] func,
  output logic       legal
);
  always_comb begin
    func  = FUNC_ARITH;
    legal = 1'b1;
    case (unit)
      UNIT_ARITH: func = FUNC_ARITH;
      UNIT_LOGIC: func = FUNC_LOGIC;
      UNIT_CMP:   func = FUNC_CMP;
      UNIT_SHIFT: func = FUNC_SHIFT;
      default:    legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/alu_cmd_issuer.sv
// Single-outstanding ALU command issuer: encode, strobe, wait fixed latency, respond.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ALU_LAT = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_unit,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [1:0]       alu_func,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_start,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             busy
);
  localparam int CW = $clog2(ALU_LAT + 1);

  issuer_state_e state, state_nx;
  logic [CW-1:0] cnt;
  logic [1:0]    enc_func;
  logic          enc_legal;
  logic          accept, done;

  alu_func_encoder u_enc (
    .unit  (cmd_unit),
    .func  (enc_func),
    .legal (enc_legal)
  );

  assign accept = (state == IDLE) && cmd_valid;
  assign done   = (state == WAIT) && (cnt == CW'(1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (cmd_valid) state_nx = enc_legal ? ISSUE : RESP;
      ISSUE: state_nx = WAIT;
      WAIT:  if (done) state_nx = RESP;
      RESP:  if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign cmd_ready = (state == IDLE);
  assign alu_start = (state == ISSUE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  // Illegal selects never touch the alu_* registers so the ALU sees no spurious change.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      alu_func <= FUNC_ARITH;
      alu_op   <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      cnt      <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      if (accept && enc_legal) begin
        alu_func <= enc_func;
        alu_op   <= cmd_op;
        alu_a    <= cmd_a;
        alu_b    <= cmd_b;
      end
      if (accept && !enc_legal) begin
        rsp_data <= '0;
        rsp_err  <= 1'b1;
      end
      if (state == ISSUE)     cnt <= CW'(ALU_LAT);
      else if (state == WAIT) cnt <= cnt - CW'(1);
      if (done) begin
        rsp_data <= alu_result;
        rsp_err  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench: two issuers (latency 1 and 4) with a delayed a+b ALU stub each.
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic [3:0]  cmd_unit  [2];
  logic [1:0]  cmd_op    [2];
  logic [15:0] cmd_a     [2];
  logic [15:0] cmd_b     [2];
  logic [1:0]  alu_func  [2];
  logic [1:0]  alu_op    [2];
  logic [15:0] alu_a     [2];
  logic [15:0] alu_b     [2];
  logic        alu_start [2];
  logic [15:0] alu_result[2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [15:0] rsp_data  [2];
  logic        rsp_err   [2];
  logic        busy      [2];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 4;
    logic [3:0]  pv;
    logic [15:0] pd [4];

    alu_cmd_issuer #(.WIDTH(16), .ALU_LAT(L)) u_dut (
      .CLK(clk), .RST(rst_n),
      .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]), .cmd_unit(cmd_unit[g]),
      .cmd_op(cmd_op[g]), .cmd_a(cmd_a[g]), .cmd_b(cmd_b[g]),
      .alu_func(alu_func[g]), .alu_op(alu_op[g]), .alu_a(alu_a[g]), .alu_b(alu_b[g]),
      .alu_start(alu_start[g]), .alu_result(alu_result[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_data(rsp_data[g]),
      .rsp_err(rsp_err[g]), .busy(busy[g])
    );

    // Result is only meaningful exactly L cycles after the start strobe; junk otherwise.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pv <= '0;
        for (int i = 0; i < 4; i++) pd[i] <= '0;
      end else begin
        pv    <= {pv[2:0], alu_start[g]};
        pd[0] <= alu_a[g] + alu_b[g];
        for (int i = 1; i < 4; i++) pd[i] <= pd[i-1];
      end
    end
    assign alu_result[g] = pv[L-1] ? pd[L-1] : (16'hBAD0 + 16'(g));
  end

  typedef struct {
    int          t0;
    bit          legal;
    logic [1:0]  func;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] data;
  } ent_t;

  ent_t        sbq [2][$];
  logic [1:0]  last_func [2];
  logic [1:0]  last_op   [2];
  logic [15:0] last_a    [2];
  logic [15:0] last_b    [2];

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic ent_t model(input int t0, input logic [3:0] u, input logic [1:0] o,
                                 input logic [15:0] a, input logic [15:0] b);
    ent_t e;
    e.t0    = t0;
    e.legal = ($countones(u) == 1);
    e.func  = 2'b00;
    for (int i = 0; i < 4; i++) if (u[i]) e.func = 2'(i);
    e.op    = o;
    e.a     = a;
    e.b     = b;
    e.data  = e.legal ? 16'(a + b) : 16'h0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out @cyc %0d", nm, cyc);
  endtask

  // Cycle-level expectations derived from the accept cycle t0 and the fixed latency.
  always @(negedge clk) begin : mon
    bit          outst, exp_rv;
    ent_t        e;
    logic [1:0]  ef, eo;
    logic [15:0] ea, eb;
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        outst = (sbq[d].size() > 0) && (sbq[d][0].t0 < cyc);
        e = '{default: 0};
        if (outst) e = sbq[d][0];
        chk("cmd_ready", cmd_ready[d], !outst);
        chk("busy", busy[d], outst);
        ef = (outst && e.legal) ? e.func : last_func[d];
        eo = (outst && e.legal) ? e.op   : last_op[d];
        ea = (outst && e.legal) ? e.a    : last_a[d];
        eb = (outst && e.legal) ? e.b    : last_b[d];
        chk("alu_func", alu_func[d], ef);
        chk("alu_op", alu_op[d], eo);
        chk("alu_a", alu_a[d], ea);
        chk("alu_b", alu_b[d], eb);
        chk("alu_start", alu_start[d], outst && e.legal && (cyc == e.t0 + 1));
        exp_rv = outst && (cyc >= e.t0 + (e.legal ? 2 + lat(d) : 1));
        chk("rsp_valid", rsp_valid[d], exp_rv);
        if (exp_rv && rsp_valid[d]) begin
          chk("rsp_data", rsp_data[d], e.data);
          chk("rsp_err", rsp_err[d], !e.legal);
          if (rsp_ready[d]) begin
            if (e.legal) begin
              last_func[d] = e.func;
              last_op[d]   = e.op;
              last_a[d]    = e.a;
              last_b[d]    = e.b;
            end
            void'(sbq[d].pop_front());
          end
        end
      end
    end
  end

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      sbq[d].delete();
      last_func[d] = '0;
      last_op[d]   = '0;
      last_a[d]    = '0;
      last_b[d]    = '0;
    end
  endtask

  task automatic chk_reset();
    for (int d = 0; d < 2; d++) begin
      chk("rst_cmd_ready", cmd_ready[d], 1);
      chk("rst_alu_func", alu_func[d], 0);
      chk("rst_alu_op", alu_op[d], 0);
      chk("rst_alu_a", alu_a[d], 0);
      chk("rst_alu_b", alu_b[d], 0);
      chk("rst_alu_start", alu_start[d], 0);
      chk("rst_rsp_valid", rsp_valid[d], 0);
      chk("rst_rsp_data", rsp_data[d], 0);
      chk("rst_rsp_err", rsp_err[d], 0);
      chk("rst_busy", busy[d], 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    chk_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int d, input logic [3:0] u, input logic [1:0] o,
                       input logic [15:0] a, input logic [15:0] b, input bit keep,
                       output int t0);
    cmd_valid[d] = 1'b1;
    cmd_unit[d]  = u;
    cmd_op[d]    = o;
    cmd_a[d]     = a;
    cmd_b[d]     = b;
    t0 = -1;
    for (int n = 0; n < 100 && t0 < 0; n++) begin
      @(negedge clk);
      if (cmd_ready[d]) begin
        t0 = cyc;
        sbq[d].push_back(model(t0, u, o, a, b));
      end
    end
    if (t0 < 0) timeout("issue_accept");
    @(posedge clk);
    #1;
    if (!keep) cmd_valid[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d, input bit rnd);
    for (int n = 0; n < 200 && sbq[d].size() > 0; n++) begin
      @(posedge clk);
      #1;
      if (rnd) rsp_ready[d] = 1'($urandom_range(0, 1));
    end
    if (sbq[d].size() > 0) begin
      timeout("rsp_wait");
      sbq[d].delete();
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish @cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t0, prev;
    logic [3:0] units [4];
    units[0] = UNIT_ARITH; units[1] = UNIT_LOGIC; units[2] = UNIT_CMP; units[3] = UNIT_SHIFT;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      cmd_valid[d] = 1'b0; cmd_unit[d] = '0; cmd_op[d] = '0;
      cmd_a[d] = '0; cmd_b[d] = '0; rsp_ready[d] = 1'b1;
    end
    clear_model();
    #12;
    chk_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All four units, latency 1, 5+3.
    for (int k = 0; k < 4; k++) begin
      issue(0, units[k], 2'(k), 16'd5, 16'd3, 1'b0, t0);
      wait_idle(0, 1'b0);
    end

    // Illegal selects leave the alu_* registers untouched.
    issue(0, 4'b0000, 2'd2, 16'd7, 16'd9, 1'b0, t0);
    wait_idle(0, 1'b0);
    issue(0, 4'b0110, 2'd1, 16'd11, 16'd12, 1'b0, t0);
    wait_idle(0, 1'b0);

    // Latency 4 with the consumer stalled well past the response.
    rsp_ready[1] = 1'b0;
    issue(1, UNIT_CMP, 2'd3, 16'hFFF0, 16'h0020, 1'b0, t0);
    repeat (10) @(posedge clk);
    #1;
    rsp_ready[1] = 1'b1;
    wait_idle(1, 1'b0);

    // Reset while waiting on the ALU, then a normal command.
    issue(1, UNIT_LOGIC, 2'd1, 16'd100, 16'd23, 1'b0, t0);
    repeat (2) @(posedge clk);
    do_reset();
    issue(1, UNIT_SHIFT, 2'd2, 16'd1000, 16'd234, 1'b0, t0);
    wait_idle(1, 1'b0);

    // Random traffic with random back-pressure.
    for (int k = 0; k < 40; k++) begin
      int d;
      logic [3:0] u;
      d = int'($urandom_range(0, 1));
      u = ($urandom_range(0, 3) == 0) ? 4'($urandom) : units[$urandom_range(0, 3)];
      issue(d, u, 2'($urandom), 16'($urandom), 16'($urandom), 1'b0, t0);
      wait_idle(d, 1'b1);
    end

    // Back-to-back: cmd_valid held high across ten commands.
    for (int d = 0; d < 2; d++) begin
      prev = -1;
      for (int k = 0; k < 10; k++) begin
        issue(d, units[$urandom_range(0, 3)], 2'($urandom), 16'($urandom), 16'($urandom),
              (k < 9), t0);
        if (prev >= 0) chk("b2b_spacing", t0 - prev, lat(d) + 3);
        prev = t0;
      end
      wait_idle(d, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
